// File: rtl/uartrx.sv
// UART receiver: 2-flop synchroniser, 16x oversampling, optional even parity, 1-2 checked stop bits.
// Define UARTRX_MAJORITY_EN to decide each bit by a 2-of-3 vote over phases 6/7/8.
module uartrx #(
  parameter int I_CLK_FRQ = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int FRAME     = 8,
  parameter int STOP      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx,
  output logic [FRAME-1:0] o_data,
  output logic             o_valid,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_busy
);

  // state | meaning
  // IDLE  | waiting for a falling edge on rx_s
  // START | confirming the start bit at mid-bit
  // DATA  | shifting in FRAME data bits, LSB first
  // PAR   | checking the even-parity bit
  // STOP  | checking STOP stop bits, then publishing the character
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  localparam int DIV   = I_CLK_FRQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(FRAME + 1);
`ifdef UARTRX_MAJORITY_EN
  localparam logic [3:0] DEC_PH = 4'd8;
`else
  localparam logic [3:0] DEC_PH = 4'd7;
`endif

  state_t             state_q;
  logic [1:0]         sync_q;
  logic               rx_prev_q;
  logic [DIV_W-1:0]   div_q;
  logic [3:0]         ph_q;
  logic [IDX_W-1:0]   idx_q;
  logic               stop_cnt_q;
  logic [FRAME-1:0]   shift_q;
  logic               par_pend_q;
  logic               frm_pend_q;
  logic [FRAME-1:0]   data_q;
  logic               valid_q;
  logic               perr_q;
  logic               ferr_q;
  logic               busy_q;

  logic rx_s;
  logic tick;
  logic start_edge;
  logic decide;
  logic bit_s;

  assign rx_s       = sync_q[1];
  assign tick       = (div_q == DIV_W'(DIV - 1));
  assign start_edge = (state_q == S_IDLE) && !rx_s && rx_prev_q;
  assign decide     = tick && (ph_q == DEC_PH) && (state_q != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], i_rx};
      rx_prev_q <= rx_s;
    end
  end

  // Divider restarts on the start edge so every tick is phase-locked to it.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_edge || tick) div_q <= '0;
    else                             div_q <= div_q + DIV_W'(1);
  end

`ifdef UARTRX_MAJORITY_EN
  logic s6_q;
  logic s7_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s6_q <= 1'b1;
      s7_q <= 1'b1;
    end else if (tick) begin
      if (ph_q == 4'd6) s6_q <= rx_s;
      if (ph_q == 4'd7) s7_q <= rx_s;
    end
  end

  assign bit_s = (s6_q & s7_q) | (s6_q & rx_s) | (s7_q & rx_s);
`else
  assign bit_s = rx_s;
`endif

  // Phase runs freely from the start edge, so each decision lands mid-bit 16 ticks apart.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick && state_q != S_IDLE) ph_q <= ph_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q <= S_START;
            ph_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (decide) begin
            if (bit_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= S_DATA;
              idx_q      <= '0;
              par_pend_q <= 1'b0;
              frm_pend_q <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (decide) begin
            shift_q[idx_q] <= bit_s;
            if (idx_q == IDX_W'(FRAME - 1)) begin
              state_q    <= (PARITY != 0) ? S_PAR : S_STOP;
              stop_cnt_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_PAR: begin
          if (decide) begin
            par_pend_q <= (bit_s != ^shift_q);
            state_q    <= S_STOP;
          end
        end
        S_STOP: begin
          if (decide) begin
            if (stop_cnt_q == 1'(STOP - 1)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              data_q  <= shift_q;
              perr_q  <= (PARITY != 0) && par_pend_q;
              ferr_q  <= frm_pend_q | ~bit_s;
            end else begin
              frm_pend_q <= frm_pend_q | ~bit_s;
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uartrx.sv
// Directed bench for uartrx: dut_a is 8N1 at DIV=54, dut_b is 8E1 at DIV=4 (64-clock bits).
module tb_uartrx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [7:0] d_a, d_b;
  logic       v_a, v_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int vcnt_a = 0, vcnt_b = 0, long_a = 0, long_b = 0;
  bit vprev_a = 0, vprev_b = 0, seen5a = 0;
  int n0;

  always #5 clk = ~clk;

  uartrx #(.I_CLK_FRQ(100_000_000), .BAUD(115200), .PARITY(0), .FRAME(8), .STOP(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .o_data(d_a), .o_valid(v_a),
    .o_parity_err(pe_a), .o_frame_err(fe_a), .o_busy(busy_a));

  uartrx #(.I_CLK_FRQ(100_000_000), .BAUD(1_500_000), .PARITY(1), .FRAME(8), .STOP(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_b), .o_data(d_b), .o_valid(v_b),
    .o_parity_err(pe_b), .o_frame_err(fe_b), .o_busy(busy_b));

  always @(posedge clk) begin
    if (v_a) vcnt_a++;
    if (v_b) vcnt_b++;
    if (v_a && vprev_a) long_a++;
    if (v_b && vprev_b) long_b++;
    if (v_b && d_b == 8'h5A) seen5a = 1;
    vprev_a = v_a;
    vprev_b = v_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                      input logic par_bit, input logic stop_bit, input int bl);
    drive_bit(sel, 1'b0, bl);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], bl);
    if (par_en) drive_bit(sel, par_bit, bl);
    drive_bit(sel, stop_bit, bl);
  endtask

  // One bit with a 4-clock inverted spike over the phase-7 sample point.
  task automatic spiked_bit(input logic v);
    drive_bit(1'b1, v, 30);
    drive_bit(1'b1, ~v, 4);
    drive_bit(1'b1, v, 30);
  endtask

  initial begin
    logic [7:0] mv;
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  {24'd0, d_a}, 32'h0);
    check("rst_valid", {31'd0, v_a}, 32'h0);
    check("rst_perr",  {31'd0, pe_a}, 32'h0);
    check("rst_ferr",  {31'd0, fe_a}, 32'h0);
    check("rst_busy",  {31'd0, busy_a}, 32'h0);
    check("rst_busy_b", {31'd0, busy_b}, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Basic 8N1 0xA5
    n0 = vcnt_a;
    drive_bit(1'b0, 1'b0, 868);
    check("basic_busy_start", {31'd0, busy_a}, 32'h1);
    mv = 8'hA5;
    for (int i = 0; i < 8; i++) drive_bit(1'b0, mv[i], 868);
    check("basic_busy_data", {31'd0, busy_a}, 32'h1);
    drive_bit(1'b0, 1'b1, 868);
    check("basic_count", vcnt_a - n0, 32'd1);
    check("basic_data",  {24'd0, d_a}, 32'hA5);
    check("basic_perr",  {31'd0, pe_a}, 32'h0);
    check("basic_ferr",  {31'd0, fe_a}, 32'h0);
    check("basic_busy_end", {31'd0, busy_a}, 32'h0);

    // Parity: 0x07 needs parity 1, sent 0; then 0x03 with correct parity 0
    n0 = vcnt_b;
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 64);
    check("par_count", vcnt_b - n0, 32'd1);
    check("par_data",  {24'd0, d_b}, 32'h07);
    check("par_perr",  {31'd0, pe_b}, 32'h1);
    check("par_ferr",  {31'd0, fe_b}, 32'h0);
    send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 64);
    check("par2_data", {24'd0, d_b}, 32'h03);
    check("par2_perr", {31'd0, pe_b}, 32'h0);

    // Framing error, then back-to-back 0x00 / 0xFF
    n0 = vcnt_a;
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 868);
    check("frm_data", {24'd0, d_a}, 32'h3C);
    check("frm_ferr", {31'd0, fe_a}, 32'h1);
    check("frm_perr", {31'd0, pe_a}, 32'h0);
    drive_bit(1'b0, 1'b1, 868);
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 868);
    check("b2b0_data", {24'd0, d_a}, 32'h00);
    check("b2b0_ferr", {31'd0, fe_a}, 32'h0);
    send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 868);
    check("b2b1_data", {24'd0, d_a}, 32'hFF);
    check("b2b1_ferr", {31'd0, fe_a}, 32'h0);
    check("b2b_count", vcnt_a - n0, 32'd3);

    // Glitch: 216 clocks low
    n0 = vcnt_a;
    rx_a = 1'b0;
    repeat (100) @(negedge clk);
    check("glitch_busy", {31'd0, busy_a}, 32'h1);
    repeat (116) @(negedge clk);
    rx_a = 1'b1;
    repeat (224) @(negedge clk);
    check("glitch_busy_fall", {31'd0, busy_a}, 32'h0);
    repeat (2000) @(negedge clk);
    check("glitch_no_valid", vcnt_a - n0, 32'd0);

    // Break on dut_b: line held low for 14 bits
    n0 = vcnt_b;
    rx_b = 1'b0;
    repeat (64 * 14) @(negedge clk);
    check("brk_count", vcnt_b - n0, 32'd1);
    check("brk_data",  {24'd0, d_b}, 32'h00);
    check("brk_ferr",  {31'd0, fe_b}, 32'h1);
    check("brk_perr",  {31'd0, pe_b}, 32'h0);
    check("brk_idle",  {31'd0, busy_b}, 32'h0);
    rx_b = 1'b1;
    repeat (200) @(negedge clk);

    // Reset during data bit 3 of 0x5A (parity 0), then 0x81 (parity 0)
    mv = 8'h5A;
    drive_bit(1'b1, 1'b0, 64);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, mv[i], 64);
    drive_bit(1'b1, mv[3], 32);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy_b}, 32'h0);
    check("midrst_data", {24'd0, d_b}, 32'h00);
    drive_bit(1'b1, mv[3], 31);
    for (int i = 4; i < 8; i++) drive_bit(1'b1, mv[i], 64);
    drive_bit(1'b1, 1'b0, 64);
    drive_bit(1'b1, 1'b1, 64 * 14);
    check("midrst_no_5a", {31'd0, seen5a}, 32'h0);
    n0 = vcnt_b;
    send(1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 64);
    check("rearm_count", vcnt_b - n0, 32'd1);
    check("rearm_data",  {24'd0, d_b}, 32'h81);
    check("rearm_perr",  {31'd0, pe_b}, 32'h0);
    check("rearm_ferr",  {31'd0, fe_b}, 32'h0);

`ifdef UARTRX_MAJORITY_EN
    // Spike on every bit of 0x96 (parity 0) must be voted out
    repeat (100) @(negedge clk);
    n0 = vcnt_b;
    mv = 8'h96;
    spiked_bit(1'b0);
    for (int i = 0; i < 8; i++) spiked_bit(mv[i]);
    spiked_bit(1'b0);
    spiked_bit(1'b1);
    check("maj_count", vcnt_b - n0, 32'd1);
    check("maj_data",  {24'd0, d_b}, 32'h96);
    check("maj_perr",  {31'd0, pe_b}, 32'h0);
    check("maj_ferr",  {31'd0, fe_b}, 32'h0);
`endif

    check("valid_width_a", long_a, 32'd0);
    check("valid_width_b", long_b, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
